// File: rtl/fpu_addsub_seq_if.sv
// Handshake bundle for the binary32 add/sub sequencer.
// Operation request, result return and busy status share this interface.
// With FPU_ADDSUB_FLAGS_EN defined it also carries the 4-bit exception flags:
// {invalid, overflow, underflow, inexact}.
interface fpu_addsub_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;
`ifdef FPU_ADDSUB_FLAGS_EN
   logic [3:0]  flags;

   modport master (output in_valid, op_a, op_b, op_sub, out_ready,
                   input  in_ready, out_valid, result, busy, flags);
   modport slave  (input  in_valid, op_a, op_b, op_sub, out_ready,
                   output in_ready, out_valid, result, busy, flags);
`else
   modport master (output in_valid, op_a, op_b, op_sub, out_ready,
                   input  in_ready, out_valid, result, busy);
   modport slave  (input  in_valid, op_a, op_b, op_sub, out_ready,
                   output in_ready, out_valid, result, busy);
`endif
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle binary32 adder/subtractor holding one operation in flight.
// Sequence: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE -> IDLE.
// Specials (NaN, inf, both-zero) and an exact cancel short-cut straight to DONE.
// Denormal inputs are flushed to signed zero; rounding is nearest-even.
// Optional feature macro: FPU_ADDSUB_FLAGS_EN adds the flags output
// {invalid, overflow, underflow, inexact}.
module fpu_addsub_seq #(
   parameter int MANT_W = 28,
   parameter int EXP_W  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   fpu_addsub_seq_if.slave bus
);
   localparam int          XW   = EXP_W + 2;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t                  state;
   logic [31:0]             a_q, b_q;
   logic                    sub_q;
   logic                    sign_a, sign_b, eff_sub;
   logic [EXP_W-1:0]        exp_a, exp_b;
   logic [MANT_W-1:0]       mant_a, mant_b;
   logic                    res_sign;
   logic signed [XW-1:0]    res_exp;
   logic [MANT_W-1:0]       res_mant;
   logic [31:0]             result_q;
   logic                    out_valid_q, in_ready_q, busy_q;

   // Align helper: right shift with every shifted-out bit folded into sticky.
   function automatic logic [MANT_W-1:0] align_shift(input logic [MANT_W-1:0] m,
                                                     input logic [EXP_W-1:0]  d);
      logic [MANT_W-1:0] mask;
      mask = ~({MANT_W{1'b1}} << d);
      if (d >= EXP_W'(MANT_W - 1))
         return {{(MANT_W-1){1'b0}}, |m};
      return (m >> d) | {{(MANT_W-1){1'b0}}, |(m & mask)};
   endfunction

   // Leading-zero count below the hidden-bit position (priority encoder).
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++)
         if (v[i]) lzc27 = 5'(26 - i);
   endfunction

   // Round-to-nearest-even on {frac, G, R, S}; returns {carry, rounded frac}.
   // The hidden bit is always set after normalisation, so a carry means the
   // fraction wrapped to zero and the exponent must step up.
   function automatic logic [23:0] round_rne(input logic [25:0] m);
      logic inc;
      inc = m[2] & (m[1] | m[0] | m[3]);
      return {inc & (&m[25:3]), m[25:3] + 23'(inc)};
   endfunction

   // Unpack: field split, denormal flush and special-case classification.
   logic [EXP_W-1:0]  ea, eb, ua_exp, ub_exp;
   logic [22:0]       fa, fb;
   logic              sa, sb, za, zb, ia, ib, na, nb;
   logic              spec, spec_invalid;
   logic [31:0]       spec_result;
   logic [MANT_W-1:0] ua_mant, ub_mant;
   always_comb begin
      ea = a_q[30:23];  fa = a_q[22:0];  sa = a_q[31];
      eb = b_q[30:23];  fb = b_q[22:0];  sb = b_q[31] ^ sub_q;
      za = (ea == '0);
      zb = (eb == '0);
      ia = (ea == '1) && (fa == '0);
      ib = (eb == '1) && (fb == '0);
      na = (ea == '1) && (fa != '0);
      nb = (eb == '1) && (fb != '0);
      ua_mant = za ? '0 : {1'b0, 1'b1, fa, 3'b000};
      ub_mant = zb ? '0 : {1'b0, 1'b1, fb, 3'b000};
      ua_exp  = za ? '0 : ea;
      ub_exp  = zb ? '0 : eb;
      spec = 1'b1;
      spec_invalid = 1'b0;
      spec_result = '0;
      if (na || nb || (ia && ib && (sa != sb))) begin
         spec_result  = QNAN;
         spec_invalid = 1'b1;
      end else if (ia) begin
         spec_result = {sa, 8'hFF, 23'b0};
      end else if (ib) begin
         spec_result = {sb, 8'hFF, 23'b0};
      end else if (za && zb) begin
         spec_result = {sa & sb, 31'b0};
      end else begin
         spec = 1'b0;
      end
   end

   // Align: compare-swap by magnitude, then shift the smaller operand.
   logic              swap, cancel;
   logic              big_sign;
   logic [EXP_W-1:0]  big_exp, exp_diff;
   logic [MANT_W-1:0] big_mant, small_sh;
   always_comb begin
      swap     = {exp_b, mant_b} > {exp_a, mant_a};
      cancel   = (sign_a != sign_b) && ({exp_a, mant_a} == {exp_b, mant_b});
      big_sign = swap ? sign_b : sign_a;
      big_exp  = swap ? exp_b  : exp_a;
      big_mant = swap ? mant_b : mant_a;
      exp_diff = swap ? (exp_b - exp_a) : (exp_a - exp_b);
      small_sh = align_shift(swap ? mant_a : mant_b, exp_diff);
   end

   // Add/sub: the larger magnitude is always in mant_a, so no borrow.
   logic [MANT_W-1:0] sum;
   always_comb begin
      sum = eff_sub ? (mant_a - mant_b) : (mant_a + mant_b);
   end

   // Normalise: carry -> shift right keeping sticky; else shift left by lzc.
   logic [4:0]           norm_lz;
   logic signed [XW-1:0] norm_exp;
   logic [MANT_W-1:0]    norm_mant;
   logic                 norm_uflow;
   always_comb begin
      norm_lz = lzc27(res_mant[26:0]);
      if (res_mant[MANT_W-1]) begin
         norm_mant = {1'b0, res_mant[MANT_W-1:2], res_mant[1] | res_mant[0]};
         norm_exp  = res_exp + XW'(1);
      end else begin
         norm_mant = res_mant << norm_lz;
         norm_exp  = res_exp - $signed(XW'(norm_lz));
      end
      norm_uflow = (norm_exp <= 0);
   end

   // Round: nearest-even, renormalise on carry, saturate to infinity.
   logic [23:0]          rnd;
   logic signed [XW-1:0] rnd_exp;
   logic                 rnd_ovf, grs;
   always_comb begin
      rnd     = round_rne(res_mant[25:0]);
      rnd_exp = rnd[23] ? (res_exp + XW'(1)) : res_exp;
      rnd_ovf = (rnd_exp >= 255);
      grs     = |res_mant[2:0];
   end

   // Sequencer FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         eff_sub     <= 1'b0;
         exp_a       <= '0;
         exp_b       <= '0;
         mant_a      <= '0;
         mant_b      <= '0;
         res_sign    <= 1'b0;
         res_exp     <= '0;
         res_mant    <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.op_a;
                  b_q        <= bus.op_b;
                  sub_q      <= bus.op_sub;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (spec) begin
                  result_q    <= spec_result;
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  sign_a <= sa;
                  sign_b <= sb;
                  exp_a  <= ua_exp;
                  exp_b  <= ub_exp;
                  mant_a <= ua_mant;
                  mant_b <= ub_mant;
                  state  <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (cancel) begin
                  result_q    <= '0;
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  res_sign <= big_sign;
                  res_exp  <= $signed({2'b00, big_exp});
                  mant_a   <= big_mant;
                  mant_b   <= small_sh;
                  eff_sub  <= sign_a ^ sign_b;
                  state    <= S_ADDSUB;
               end
            end
            S_ADDSUB: begin
               if (sum == '0) begin
                  result_q    <= '0;
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  res_mant <= sum;
                  state    <= S_NORM;
               end
            end
            S_NORM: begin
               if (norm_uflow) begin
                  result_q    <= {res_sign, 31'b0};
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  res_mant <= norm_mant;
                  res_exp  <= norm_exp;
                  state    <= S_ROUND;
               end
            end
            S_ROUND: begin
               if (rnd_ovf)
                  result_q <= {res_sign, 8'hFF, 23'b0};
               else
                  result_q <= {res_sign, rnd_exp[EXP_W-1:0], rnd[22:0]};
               out_valid_q <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.busy      = busy_q;

`ifdef FPU_ADDSUB_FLAGS_EN
   logic [3:0] flags_q;

   // Exception flags {invalid, overflow, underflow, inexact}, cleared on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         case (state)
            S_IDLE:   if (bus.in_valid) flags_q <= '0;
            S_UNPACK: if (spec) flags_q <= {spec_invalid, 3'b000};
            S_NORM:   if (norm_uflow) flags_q <= 4'b0011;
            S_ROUND:  flags_q <= rnd_ovf ? 4'b0101 : {3'b000, grs};
            default:  flags_q <= flags_q;
         endcase
      end
   end

   assign bus.flags = flags_q;
`endif
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq: reset, add/sub, cancel, rounding ties,
// specials and output backpressure, with hand-computed binary32 results.
module tb_fpu_addsub_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   fpu_addsub_seq_if bus ();

   fpu_addsub_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Drives one operation with out_ready high; returns result, flags and the
   // latency counted in clock edges from the accept edge (inclusive).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] res, output int lat, output logic [3:0] fl);
      @(negedge clk);
      bus.op_a = a;
      bus.op_b = b;
      bus.op_sub = sub;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.result;
`ifdef FPU_ADDSUB_FLAGS_EN
      fl = bus.flags;
`else
      fl = 4'b0000;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
      checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", bus.result); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      bus.op_a = 32'h3F80_0000;
      bus.op_b = 32'h3F80_0000;
      bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); else passed++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++; if (seen !== 0) $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); else passed++;
   endtask

   task automatic test_add();
      logic [31:0] r; int lat; logic [3:0] fl;
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h4000_0000) $display("FAIL add_1p1: got %h want 40000000", r); else passed++;
      checks++; if (lat !== 6) $display("FAIL add_latency: got %0d want 6", lat); else passed++;
      run_op(32'h3FC0_0000, 32'h4010_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h4070_0000) $display("FAIL add_1p5_2p25: got %h want 40700000", r); else passed++;
      checks++; if (lat !== 6) $display("FAIL add2_latency: got %0d want 6", lat); else passed++;
      run_op(32'h3F80_0000, 32'hBF80_0000, 1'b1, r, lat, fl);
      checks++; if (r !== 32'h4000_0000) $display("FAIL sub_neg: got %h want 40000000", r); else passed++;
   endtask

   task automatic test_cancel();
      logic [31:0] r; int lat; logic [3:0] fl;
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, r, lat, fl);
      checks++; if (r !== 32'h0000_0000) $display("FAIL cancel_exact: got %h want 00000000", r); else passed++;
      checks++; if (lat !== 3) $display("FAIL cancel_latency: got %0d want 3", lat); else passed++;
      run_op(32'h4010_0000, 32'h3FC0_0000, 1'b1, r, lat, fl);
      checks++; if (r !== 32'h3F40_0000) $display("FAIL cancel_partial: got %h want 3f400000", r); else passed++;
      checks++; if (lat !== 6) $display("FAIL cancel_partial_lat: got %0d want 6", lat); else passed++;
   endtask

   task automatic test_tie_even();
      logic [31:0] r; int lat; logic [3:0] fl;
      run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h3F80_0000) $display("FAIL tie_down: got %h want 3f800000", r); else passed++;
`ifdef FPU_ADDSUB_FLAGS_EN
      checks++; if (fl !== 4'b0001) $display("FAIL tie_flags: got %b want 0001", fl); else passed++;
`endif
      run_op(32'h3F80_0001, 32'h3380_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h3F80_0002) $display("FAIL tie_up: got %h want 3f800002", r); else passed++;
   endtask

   task automatic test_specials();
      logic [31:0] r; int lat; logic [3:0] fl;
      run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h7FC0_0000) $display("FAIL inf_minus_inf: got %h want 7fc00000", r); else passed++;
      checks++; if (lat !== 2) $display("FAIL special_latency: got %0d want 2", lat); else passed++;
`ifdef FPU_ADDSUB_FLAGS_EN
      checks++; if (fl !== 4'b1000) $display("FAIL invalid_flags: got %b want 1000", fl); else passed++;
`endif
      run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h7F80_0000) $display("FAIL overflow_inf: got %h want 7f800000", r); else passed++;
`ifdef FPU_ADDSUB_FLAGS_EN
      checks++; if (fl !== 4'b0101) $display("FAIL overflow_flags: got %b want 0101", fl); else passed++;
`endif
      run_op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'h7FC0_0000) $display("FAIL nan_in: got %h want 7fc00000", r); else passed++;
      run_op(32'h8000_0000, 32'h0000_0000, 1'b1, r, lat, fl);
      checks++; if (r !== 32'h8000_0000) $display("FAIL neg_zeros: got %h want 80000000", r); else passed++;
      checks++; if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat); else passed++;
      run_op(32'hFF80_0000, 32'h4000_0000, 1'b0, r, lat, fl);
      checks++; if (r !== 32'hFF80_0000) $display("FAIL inf_pass: got %h want ff800000", r); else passed++;
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      @(negedge clk);
      bus.op_a = 32'h3FC0_0000;
      bus.op_b = 32'h4010_0000;
      bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.op_a = 32'h4000_0000;
      bus.op_b = 32'h4000_0000;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat !== 6) $display("FAIL bp_latency: got %0d want 6", lat); else passed++;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b1 || bus.result !== 32'h4070_0000 ||
             bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0 (result %h)", bad, bus.result); else passed++;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else passed++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else passed++;
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) $display("FAIL bp_ignored_op: got busy %b want 0", bus.busy); else passed++;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.op_sub = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_reset_mid_op();
      test_add();
      test_cancel();
      test_tie_even();
      test_specials();
      test_backpressure();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
Multi-cycle sequencer for the single-precision FP adder-subtractor datapath. It accepts IEEE-754 binary32 operands and an add/sub opcode over a valid/ready handshake. It steps through unpack, compare-swap, align, add/sub, normalize and round stages and returns the packed binary32 result. It sits between the core's FP issue logic and the writeback mux, and holds one operation in flight.

Parameters:
MANT_W, 28, internal mantissa width: hidden bit, 23 fraction bits, plus overflow/guard/round/sticky extension; fixed at 28 for binary32.
EXP_W, 8, exponent width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode are valid
in_ready  out  1  block is idle and can accept an operation
op_a  in  32  operand A, binary32
op_b  in  32  operand B, binary32
op_sub  in  1  0 = A+B, 1 = A−B (inverts sign of B at unpack)
out_valid  out  1  result is valid
out_ready  in  1  consumer accepts the result
result  out  32  binary32 result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; busy=0; all internal registers cleared. Asserting reset mid-operation aborts the operation; no result is produced.
- States: IDLE → UNPACK → ALIGN → ADDSUB → NORM → ROUND → DONE → IDLE.
- IDLE: in_ready=1. A transfer completes when in_valid&&in_ready; operands and op_sub are latched on that edge and the next state is UNPACK.
- UNPACK: splits each operand into sign, 8-bit exponent and 28-bit mantissa {0,hidden,frac[22:0],3'b000}. Denormal inputs are flushed to ±0. Classifies zero/inf/NaN.
  - Special cases go directly to DONE with the result preloaded:
    - Any NaN → 0x7FC00000.
    - inf + (−inf) after sign adjust → 0x7FC00000.
    - ±inf with any other operand → that inf.
    - Both zero → +0, except (−0)+(−0) → 0x80000000.
  - Otherwise the FSM moves to ALIGN.
- ALIGN: compare-swap so the larger-magnitude operand (exponent, then mantissa) is A. Its exponent is kept as result exponent. The smaller operand is right-shifted by the exponent difference in one cycle. Shifted-out bits are ORed into the sticky bit. A difference ≥ 27 yields mantissa 0 with sticky = (smaller operand ≠ 0).
- ADDSUB: same effective sign → add mantissas; otherwise subtract smaller from larger, with the result sign taken from the larger operand. An exact-zero difference yields +0 and goes to DONE.
- NORM: if there is a carry out, shift right 1 (preserving sticky) and increment the exponent. Otherwise, left-shift by the leading-zero count (single cycle, priority encoder) and decrement the exponent. If the exponent would fall ≤ 0, flush to signed zero.
- ROUND: round to nearest, ties to even, using guard/round/sticky. A mantissa overflow from rounding renormalizes and increments the exponent. An exponent ≥ 255 gives signed infinity.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid&&out_ready the FSM returns to IDLE. in_ready stays 0 until IDLE, so there is no back-to-back accept in the same cycle.
- Latency from the accept edge to out_valid: 6 cycles for the normal path, 2 cycles for the special/early-zero path (3 for an exact-cancel zero).
- in_valid while busy is ignored; operands must be held by the producer.

Optional Feature:
FPU_ADDSUB_FLAGS_EN.
- When defined, a 4-bit output flags {invalid, overflow, underflow, inexact} is added.
  - flags is valid with out_valid and cleared to 0 on reset and on each accept.
  - invalid: NaN-producing case.
  - overflow: rounding to inf.
  - underflow: flush to zero of a nonzero result.
  - inexact: any nonzero G/R/S, overflow, or underflow.
- When undefined, the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-op: accept 0x3F800000+0x3F800000, pull rst_n low in ALIGN → out_valid=0, in_ready=1 immediately, no result appears.
- Add: 0x3F800000+0x3F800000, op_sub=0 → result 0x40000000, out_valid exactly 6 cycles after accept; 0x3FC00000+0x40100000 → 0x40700000.
- Cancel: 0x3F800000−0x3F800000 → 0x00000000; 0x40100000−0x3FC00000 → 0x3F400000.
- Tie to even: 0x3F800000+0x33800000 → 0x3F800000, inexact=1 with flags enabled; 0x3F800001+0x33800000 → 0x3F800002.
- Specials: 0x7F800000+0xFF800000 → 0x7FC00000 in 2 cycles (invalid=1); 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 (overflow=1, inexact=1).
- Backpressure: hold out_ready=0 for 10 cycles → result and out_valid stable, in_ready=0, new in_valid ignored; release → IDLE next cycle.
